// File: rtl/ipg_tx_arb.sv
// ipg_tx_arb: multi-channel IPG message inserter between the 64b/66b encoder and the gearbox.
// Forwards the encoded stream with one cycle of latency. Eligible idle blocks are replaced by
// message blocks from NUM_CH channel FIFOs, which are served round-robin. A multi-block message
// locks the arbiter to its channel until the last block has been sent.
// Optional build macro IPG_TX_ARB_STATS_EN adds the stat_ins_cnt / stat_idle_cnt counters.
module ipg_tx_arb #(
    parameter int         NUM_CH     = 2,
    parameter int         FIFO_DEPTH = 8,
    parameter int         MIN_IDLE   = 2,
    parameter logic [7:0] IPG_BT     = 8'h4b
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [1:0]           enc_tx_hdr,
    input  logic [63:0]          enc_tx_data,
    input  logic [NUM_CH-1:0]    ch_wr_valid,
    input  logic [NUM_CH*52-1:0] ch_wr_data,
    input  logic [NUM_CH-1:0]    ch_wr_last,
    output logic [NUM_CH-1:0]    ch_wr_ready,
    output logic [1:0]           out_tx_hdr,
    output logic [63:0]          out_tx_data,
    output logic                 out_ins
`ifdef IPG_TX_ARB_STATS_EN
    ,
    output logic [31:0]          stat_ins_cnt,
    output logic [31:0]          stat_idle_cnt
`endif
);

    localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int IRW = (MIN_IDLE > 0) ? $clog2(MIN_IDLE + 1) : 1;

    // FIFO storage: bit 52 is the last-block flag, bits 51:0 the payload
    logic [52:0]   fifo_mem [NUM_CH][FIFO_DEPTH];

    logic [PW-1:0] wr_ptr_q [NUM_CH];
    logic [PW-1:0] wr_ptr_d [NUM_CH];
    logic [PW-1:0] rd_ptr_q [NUM_CH];
    logic [PW-1:0] rd_ptr_d [NUM_CH];
    logic [PW:0]   count_q  [NUM_CH];
    logic [PW:0]   count_d  [NUM_CH];

    logic [NUM_CH-1:0] fifo_empty;
    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] pop;

    logic [IRW-1:0] idle_run_q, idle_run_d;
    logic           lock_q, lock_d;
    logic [CW-1:0]  lock_ch_q, lock_ch_d;
    logic [CW-1:0]  rr_q, rr_d;

    logic [1:0]     out_tx_hdr_q, out_tx_hdr_d;
    logic [63:0]    out_tx_data_q, out_tx_data_d;
    logic           out_ins_q, out_ins_d;

    logic           in_idle;
    logic           run_ok;
    logic           do_ins;
    logic           sel_valid;
    logic [CW-1:0]  sel_ch;
    logic [52:0]    head;

    // FIFO status from registered counts; a full FIFO refuses writes
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            fifo_empty[i]  = (count_q[i] == '0);
            ch_wr_ready[i] = (count_q[i] != (PW+1)'(FIFO_DEPTH));
            push[i]        = ch_wr_valid[i] && ch_wr_ready[i];
        end
    end

    // Channel selection: locked channel only, else first non-empty from the rr pointer upward
    always_comb begin
        int idx;
        idx       = 0;
        sel_valid = 1'b0;
        sel_ch    = '0;
        if (lock_q) begin
            sel_ch    = lock_ch_q;
            sel_valid = !fifo_empty[lock_ch_q];
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                idx = int'(rr_q) + k;
                if (idx >= NUM_CH) begin
                    idx = idx - NUM_CH;
                end
                if (!sel_valid && !fifo_empty[CW'(idx)]) begin
                    sel_valid = 1'b1;
                    sel_ch    = CW'(idx);
                end
            end
        end
    end

    // Slot decision, output block, idle-run tracking, lock/round-robin update and FIFO pointers
    always_comb begin
        in_idle       = (enc_tx_hdr == 2'b01) && (enc_tx_data == 64'h000000000000001E);
        run_ok        = (idle_run_q >= IRW'(MIN_IDLE));
        do_ins        = in_idle && run_ok && sel_valid;
        head          = fifo_mem[sel_ch][rd_ptr_q[sel_ch]];

        idle_run_d    = '0;
        if (in_idle) begin
            idle_run_d = run_ok ? idle_run_q : idle_run_q + IRW'(1);
        end

        lock_d        = lock_q;
        lock_ch_d     = lock_ch_q;
        rr_d          = rr_q;
        out_tx_hdr_d  = enc_tx_hdr;
        out_tx_data_d = enc_tx_data;
        out_ins_d     = 1'b0;
        if (do_ins) begin
            out_tx_hdr_d  = 2'b01;
            out_tx_data_d = {head[51:0], 4'(sel_ch), IPG_BT};
            out_ins_d     = 1'b1;
            if (head[52]) begin
                lock_d = 1'b0;
                rr_d   = (sel_ch == CW'(NUM_CH - 1)) ? '0 : sel_ch + CW'(1);
            end else begin
                lock_d    = 1'b1;
                lock_ch_d = sel_ch;
            end
        end

        for (int i = 0; i < NUM_CH; i++) begin
            pop[i]      = do_ins && (sel_ch == CW'(i));
            wr_ptr_d[i] = push[i] ? wr_ptr_q[i] + PW'(1) : wr_ptr_q[i];
            rd_ptr_d[i] = pop[i]  ? rd_ptr_q[i] + PW'(1) : rd_ptr_q[i];
            count_d[i]  = count_q[i] + (PW+1)'(push[i]) - (PW+1)'(pop[i]);
        end
    end

    // FIFO data storage; needs no reset because the counts gate every read
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (push[i]) begin
                fifo_mem[i][wr_ptr_q[i]] <= {ch_wr_last[i], ch_wr_data[52*i +: 52]};
            end
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
            idle_run_q    <= IRW'(MIN_IDLE);
            lock_q        <= 1'b0;
            lock_ch_q     <= '0;
            rr_q          <= '0;
            out_tx_hdr_q  <= 2'b01;
            out_tx_data_q <= 64'h000000000000001E;
            out_ins_q     <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
                count_q[i]  <= count_d[i];
            end
            idle_run_q    <= idle_run_d;
            lock_q        <= lock_d;
            lock_ch_q     <= lock_ch_d;
            rr_q          <= rr_d;
            out_tx_hdr_q  <= out_tx_hdr_d;
            out_tx_data_q <= out_tx_data_d;
            out_ins_q     <= out_ins_d;
        end
    end

    assign out_tx_hdr  = out_tx_hdr_q;
    assign out_tx_data = out_tx_data_q;
    assign out_ins     = out_ins_q;

`ifdef IPG_TX_ARB_STATS_EN
    logic [31:0] stat_ins_cnt_q, stat_ins_cnt_d;
    logic [31:0] stat_idle_cnt_q, stat_idle_cnt_d;

    // Count inserted blocks and eligible idle slots that no channel could fill
    always_comb begin
        stat_ins_cnt_d  = stat_ins_cnt_q + 32'(do_ins);
        stat_idle_cnt_d = stat_idle_cnt_q + 32'(in_idle && run_ok && !sel_valid);
    end

    // Statistics registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_ins_cnt_q  <= '0;
            stat_idle_cnt_q <= '0;
        end else begin
            stat_ins_cnt_q  <= stat_ins_cnt_d;
            stat_idle_cnt_q <= stat_idle_cnt_d;
        end
    end

    assign stat_ins_cnt  = stat_ins_cnt_q;
    assign stat_idle_cnt = stat_idle_cnt_q;
`endif

endmodule
